// File: rtl/spi_reg_slave_if.sv
// Bus bundle for spi_reg_slave: SPI pins plus the local register port.
interface spi_reg_slave_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       lwr_en;
    logic [3:0] lwr_addr;
    logic [7:0] lwr_data;
    logic [3:0] lrd_addr;
    logic [7:0] lrd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       frame_err;

    modport slave (
        input  sclk, cs_n, mosi, lwr_en, lwr_addr, lwr_data, lrd_addr,
        output miso, miso_oe, lrd_data, wr_valid, wr_addr, wr_data, rd_valid, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, lwr_en, lwr_addr, lwr_data, lrd_addr,
        input  miso, miso_oe, lrd_data, wr_valid, wr_addr, wr_data, rd_valid, frame_err
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register responder: 16 x 8-bit register file reached by 16-bit
// SPI frames, with a local write/read port for on-chip logic.
module spi_reg_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic           iclk,
    input  logic           irstn,
    spi_reg_slave_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StDone} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_assert, cs_deassert;

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    // Earlier 15 frame bits; the 16th is mosi_s itself in shift_in.
    logic [14:0] shift_q, shift_d;
    logic [15:0] shift_in;
    logic [7:0]  tx_q, tx_d;
    logic [3:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic        rd_valid_q, rd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        spi_we;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign cs_assert   = ~cs_s & cs_prev_q;
    assign cs_deassert = cs_s & ~cs_prev_q;

    assign shift_in = {shift_q, mosi_s};

    // Synchronizers and edge-detect history. The cs chain resets to "asserted"
    // so a cs_n already low at reset release never looks like a new assert.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Frame FSM next state; cs deassert takes priority over any sclk edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        spi_we      = 1'b0;
        if (cs_deassert) begin
            frame_err_d = (state_q == StCmd) || (state_q == StWdata) || (state_q == StRdata);
            state_d     = StIdle;
            miso_d      = 1'b0;
            oe_d        = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_assert) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[14:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            addr_d = shift_in[3:0];
                            if (shift_in[7]) begin
                                tx_d       = regs_q[shift_in[3:0]];
                                rd_valid_d = 1'b1;
                                oe_d       = 1'b1;
                                state_d    = StRdata;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[14:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            spi_we     = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = shift_in[7:0];
                            wr_valid_d = 1'b1;
                            state_d    = StDone;
                        end
                    end
                end
                StRdata: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[14:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = StDone;
                        end
                    end else if (sclk_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Register file next state; the SPI write is applied last so it wins a
    // same-address collision with the local port.
    always_comb begin
        regs_d = regs_q;
        if (bus.lwr_en) regs_d[bus.lwr_addr] = bus.lwr_data;
        if (spi_we)     regs_d[addr_q]       = shift_in[7:0];
    end

    // State, outputs and register file.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = oe_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.lrd_data  = regs_q[bus.lrd_addr];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: SPI master model at iclk/8 with a
// scoreboard of expected SPI writes and read-back bytes.
module tb_spi_reg_slave;

    localparam logic [7:0] RST_V = 8'h5A;

    logic iclk = 1'b0;
    logic irstn;
    always #5 iclk = ~iclk;

    spi_reg_slave_if bus ();

    spi_reg_slave #(
        .SYNC_STAGES(2),
        .RESET_VAL  (RST_V)
    ) dut (
        .iclk (iclk),
        .irstn(irstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ferr_cnt = 0;

    logic [11:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        bus.lwr_addr = a;
        bus.lwr_data = d;
        bus.lwr_en   = 1'b1;
        wait_cyc(1);
        bus.lwr_en   = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        bus.lrd_addr = a;
        #1;
        d = bus.lrd_data;
    endtask

    // One SPI frame of nbits, half period 4 iclk. A local write can be fired
    // so it lands on the same iclk edge as the slave's handling of rise lw_bit.
    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit raise_cs,
                             input bit expect_read, input int lw_bit,
                             input logic [3:0] lw_addr, input logic [7:0] lw_data);
        logic [7:0] rx;
        logic [7:0] e;
        rx = '0;
        bus.cs_n = 1'b0;
        bus.sclk = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = word[15-i];
            wait_cyc(4);
            bus.sclk = 1'b1;
            if (i == 0) check_eq("oe_cmd", bus.miso_oe, 0);
            if (i == 9) check_eq("oe_data", bus.miso_oe, expect_read);
            if (i >= 8) rx = {rx[6:0], bus.miso};
            if (i == lw_bit) begin
                wait_cyc(2);
                bus.lwr_addr = lw_addr;
                bus.lwr_data = lw_data;
                bus.lwr_en   = 1'b1;
                wait_cyc(1);
                bus.lwr_en   = 1'b0;
                wait_cyc(1);
            end else begin
                wait_cyc(4);
            end
            bus.sclk = 1'b0;
        end
        wait_cyc(4);
        if (raise_cs) begin
            bus.cs_n = 1'b1;
            wait_cyc(6);
            check_eq("oe_idle", bus.miso_oe, 0);
            check_eq("miso_idle", bus.miso, 0);
        end
        if (expect_read && nbits == 16) begin
            if (exp_rd.size() == 0) begin
                check_eq("rd_unexp", 1, 0);
            end else begin
                e = exp_rd.pop_front();
                check_eq("rd_data", rx, e);
            end
        end
    endtask

    // Output monitor: pops expected writes and counts pulses.
    logic [11:0] e_wr;
    always @(negedge iclk) begin
        if (irstn) begin
            if (bus.wr_valid) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check_eq("wr_unexp", 1, 0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check_eq("wr_addr", bus.wr_addr, e_wr[11:8]);
                    check_eq("wr_data", bus.wr_data, e_wr[7:0]);
                end
            end
            if (bus.rd_valid) rd_cnt++;
            if (bus.frame_err) ferr_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int r0, w0, f0, bad;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.lwr_en = 1'b0;
        bus.lwr_addr = '0;
        bus.lwr_data = '0;
        bus.lrd_addr = '0;
        irstn = 1'b0;
        wait_cyc(3);
        irstn = 1'b1;
        wait_cyc(6);

        // Reset state
        check_eq("rst_miso", bus.miso, 0);
        check_eq("rst_oe", bus.miso_oe, 0);
        check_eq("rst_wr_valid", bus.wr_valid, 0);
        check_eq("rst_rd_valid", bus.rd_valid, 0);
        check_eq("rst_frame_err", bus.frame_err, 0);
        check_eq("rst_wr_addr", bus.wr_addr, 0);
        check_eq("rst_wr_data", bus.wr_data, 0);
        read_reg(4'h0, d);
        check_eq("rst_reg0", d, RST_V);

        // SPI write addr 3 = A5
        exp_wr.push_back({4'h3, 8'hA5});
        spi_frame(16'h03A5, 16, 1, 0, -1, 4'h0, 8'h00);
        check_eq("wr_cnt1", wr_cnt, 1);
        read_reg(4'h3, d);
        check_eq("reg3", d, 8'hA5);

        // Local write then SPI read of reg5
        local_write(4'h5, 8'h3C);
        read_reg(4'h5, d);
        check_eq("lrd_reg5", d, 8'h3C);
        r0 = rd_cnt;
        exp_rd.push_back(8'h3C);
        spi_frame(16'h8500, 16, 1, 1, -1, 4'h0, 8'h00);
        check_eq("rd_cnt1", rd_cnt, r0 + 1);

        // Back-to-back write F = 81 then read F
        exp_wr.push_back({4'hF, 8'h81});
        spi_frame(16'h0F81, 16, 1, 0, -1, 4'h0, 8'h00);
        wait_cyc(16);
        exp_rd.push_back(8'h81);
        spi_frame(16'h8F00, 16, 1, 1, -1, 4'h0, 8'h00);
        check_eq("ferr_none", ferr_cnt, 0);

        // Aborted write after 11 bits
        w0 = wr_cnt;
        spi_frame(16'h02FF, 11, 1, 0, -1, 4'h0, 8'h00);
        check_eq("ferr_abort", ferr_cnt, 1);
        check_eq("wr_cnt_abort", wr_cnt, w0);
        read_reg(4'h2, d);
        check_eq("reg2_kept", d, RST_V);

        // Same-cycle local 11 and SPI 22 to reg7
        exp_wr.push_back({4'h7, 8'h22});
        spi_frame(16'h0722, 16, 1, 0, 15, 4'h7, 8'h11);
        read_reg(4'h7, d);
        check_eq("reg7_collide", d, 8'h22);

        // Local write to reg7 during its read: snapshot is shifted out
        exp_rd.push_back(8'h22);
        spi_frame(16'h8700, 16, 1, 1, 10, 4'h7, 8'h99);
        read_reg(4'h7, d);
        check_eq("reg7_local", d, 8'h99);

        // Reset in the middle of a read frame
        spi_frame(16'h8300, 12, 0, 1, -1, 4'h0, 8'h00);
        f0 = ferr_cnt;
        irstn = 1'b0;
        #1;
        check_eq("mrst_miso", bus.miso, 0);
        check_eq("mrst_oe", bus.miso_oe, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_reg(i[3:0], d);
            if (d !== RST_V) bad++;
        end
        check_eq("mrst_regs", bad, 0);
        wait_cyc(3);
        irstn = 1'b1;
        wait_cyc(4);
        // cs_n is still low: this frame must be ignored
        r0 = rd_cnt;
        w0 = wr_cnt;
        spi_frame(16'h8100, 16, 1, 0, -1, 4'h0, 8'h00);
        check_eq("idle_rd", rd_cnt, r0);
        check_eq("idle_wr", wr_cnt, w0);
        check_eq("idle_ferr", ferr_cnt, f0);
        wait_cyc(16);
        exp_rd.push_back(RST_V);
        spi_frame(16'h8000, 16, 1, 1, -1, 4'h0, 8'h00);
        check_eq("rd_cnt_post", rd_cnt, r0 + 1);

        wait_cyc(4);
        check_eq("wr_pending", exp_wr.size(), 0);
        check_eq("rd_pending", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
